// File: rtl/alu_result_stage_if.sv
// Flag type shared with the ALU, plus the handshake/data bundle for alu_result_stage.
// The "master" modport is the environment side (upstream producer plus downstream
// consumer). The "slave" modport is the stage itself.

package defs;
    typedef struct packed {
        logic sign;
        logic zero;
        logic overflow;
        logic carryOut;
    } t_flag;
endpackage

interface alu_result_stage_if #(
    parameter int N  = 32,
    parameter int RW = 5
);
    // upstream side
    logic          iValid;
    logic          oReady;
    logic [N-1:0]  iF;
    defs::t_flag   iFlag;
    logic [RW-1:0] iRd;
    logic          iWe;
    logic          iIsBranch;
    logic [2:0]    iCond;

    // downstream side
    logic          oValid;
    logic          iReady;
    logic [N-1:0]  oF;
    defs::t_flag   oFlag;
    logic [RW-1:0] oRd;
    logic          oWe;
    logic          oTaken;

    modport master (
        output iValid, iF, iFlag, iRd, iWe, iIsBranch, iCond, iReady,
        input  oReady, oValid, oF, oFlag, oRd, oWe, oTaken
    );

    modport slave (
        input  iValid, iF, iFlag, iRd, iWe, iIsBranch, iCond, iReady,
        output oReady, oValid, oF, oFlag, oRd, oWe, oTaken
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered stage after the ALU with a 2-entry skid buffer.
// It resolves the branch condition and the writeback enable when an entry is
// accepted. The MAIN entry drives the outputs. The SKID entry absorbs one extra
// accept while MAIN is stalled, so oReady depends only on registered state and iRst.
// Optional feature macro: ALU_RESULT_STICKY_OVF_EN. It adds iOvfClr/oOvfSticky,
// a sticky overflow flag that is set by non-branch entries leaving the stage.

module alu_result_stage #(
    parameter int N  = 32,
    parameter int RW = 5
) (
    input  logic                   iClk,
    input  logic                   iRst,
`ifdef ALU_RESULT_STICKY_OVF_EN
    input  logic                   iOvfClr,
    output logic                   oOvfSticky,
`endif
    alu_result_stage_if.slave      bus
);

    typedef struct packed {
        logic [N-1:0]  f;
        defs::t_flag   flag;
        logic [RW-1:0] rd;
        logic          we;
        logic          taken;
        logic          is_branch;
    } entry_t;

    entry_t main_entry;
    entry_t skid_entry;
    entry_t in_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   transfer;
    logic   taken;

    assign bus.oReady = ~skid_valid & ~iRst;
    assign bus.oValid = main_valid;
    assign accept     = bus.iValid & bus.oReady;
    assign transfer   = main_valid & bus.iReady;

    assign bus.oF     = main_entry.f;
    assign bus.oFlag  = main_entry.flag;
    assign bus.oRd    = main_entry.rd;
    assign bus.oWe    = main_entry.we;
    assign bus.oTaken = main_entry.taken;

    // Decode the branch condition and assemble the entry to store on accept.
    always_comb begin
        taken = 1'b0;
        if (bus.iIsBranch) begin
            case (bus.iCond)
                3'b000:  taken = bus.iFlag.zero;
                3'b001:  taken = ~bus.iFlag.zero;
                3'b100:  taken = bus.iFlag.sign ^ bus.iFlag.overflow;
                3'b101:  taken = ~(bus.iFlag.sign ^ bus.iFlag.overflow);
                3'b110:  taken = bus.iFlag.carryOut;
                3'b111:  taken = ~bus.iFlag.carryOut;
                default: taken = 1'b0;
            endcase
        end
        in_entry.f         = bus.iF;
        in_entry.flag      = bus.iFlag;
        in_entry.rd        = bus.iRd;
        in_entry.we        = bus.iWe & (bus.iRd != '0);
        in_entry.taken     = taken;
        in_entry.is_branch = bus.iIsBranch;
    end

    // Move entries between SKID and MAIN. A drained SKID refills MAIN first.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_entry <= '0;
            skid_entry <= '0;
        end else if (transfer && skid_valid) begin
            main_entry <= skid_entry;
            skid_valid <= 1'b0;
        end else if (accept && (!main_valid || transfer)) begin
            main_entry <= in_entry;
            main_valid <= 1'b1;
        end else if (accept) begin
            skid_entry <= in_entry;
            skid_valid <= 1'b1;
        end else if (transfer) begin
            main_valid <= 1'b0;
        end
    end

`ifdef ALU_RESULT_STICKY_OVF_EN
    // Sticky overflow: set by an overflowing non-branch entry leaving the stage. Clear wins.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            oOvfSticky <= 1'b0;
        end else if (iOvfClr) begin
            oOvfSticky <= 1'b0;
        end else if (transfer && main_entry.flag.overflow && !main_entry.is_branch) begin
            oOvfSticky <= 1'b1;
        end
    end
`endif

endmodule
